// File: rtl/lc4_divider_seq_pkg.sv
// Shared LC4 divider definitions: datapath width, FSM encoding, iteration count helper.
package lc4_divider_seq_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // Number of busy cycles needed to resolve all quotient bits.
  function automatic int unsigned iter_count(input int unsigned bits_per_cycle);
    return WORD_W / bits_per_cycle;
  endfunction

endpackage

// File: rtl/lc4_div_step.sv
// One restoring division step: shift in a dividend bit, conditionally subtract the divisor.
module lc4_div_step
  import lc4_divider_seq_pkg::*;
(
  input  logic [WORD_W-1:0] rem,
  input  logic              dvd_bit,
  input  logic [WORD_W-1:0] divisor,
  output logic [WORD_W-1:0] rem_next,
  output logic              q_bit
);

  logic [WORD_W:0] shifted;
  logic [WORD_W:0] diff;

  // 17-bit compare/subtract so a shifted remainder above 0xFFFF is handled.
  always_comb begin
    shifted  = {rem, dvd_bit};
    diff     = shifted - {1'b0, divisor};
    q_bit    = (shifted >= {1'b0, divisor});
    rem_next = q_bit ? WORD_W'(diff) : WORD_W'(shifted);
  end

endmodule

// File: rtl/lc4_divider_seq.sv
// Sequential 16-bit unsigned restoring divider for the LC4 ALU DIV/MOD paths.
module lc4_divider_seq
  import lc4_divider_seq_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [WORD_W-1:0] i_dividend,
  input  logic [WORD_W-1:0] i_divisor,
  output logic              o_busy,
  output logic              o_valid,
  output logic [WORD_W-1:0] o_quotient,
  output logic [WORD_W-1:0] o_remainder
);

  localparam int unsigned ITERS = iter_count(BITS_PER_CYCLE);
  localparam int unsigned CNT_W = $clog2(WORD_W + 1);

  div_state_e state_q, state_d;

  logic              accept, step_en, finish;
  logic [CNT_W-1:0]  cnt_q;
  logic [WORD_W-1:0] dvd_q, dvs_q, rem_q;
  logic [WORD_W-1:0] dvd_next;
  logic [WORD_W-1:0] rem_c [BITS_PER_CYCLE+1];
  logic [BITS_PER_CYCLE-1:0] q_c;
  logic              busy_q, valid_q;
  logic [WORD_W-1:0] quo_q, remo_q;

  // Chain of restoring steps, MSB of the dividend shift register first.
  assign rem_c[0] = rem_q;
  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    lc4_div_step u_step (
      .rem      (rem_c[g]),
      .dvd_bit  (dvd_q[WORD_W-1-g]),
      .divisor  (dvs_q),
      .rem_next (rem_c[g+1]),
      .q_bit    (q_c[BITS_PER_CYCLE-1-g])
    );
  end

  // Dividend bits shift out the top while quotient bits fill in from the bottom.
  assign dvd_next = {dvd_q[WORD_W-BITS_PER_CYCLE-1:0], q_c};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and control decode.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step_en = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          accept  = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        step_en = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          finish  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (i_start) begin
          accept  = 1'b1;
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs; results only change on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      quo_q   <= '0;
      remo_q  <= '0;
    end else begin
      busy_q  <= (state_d == ST_BUSY);
      valid_q <= finish;
      if (accept) begin
        dvd_q <= i_dividend;
        dvs_q <= i_divisor;
        rem_q <= '0;
        cnt_q <= CNT_W'(ITERS);
      end else if (step_en) begin
        dvd_q <= dvd_next;
        rem_q <= rem_c[BITS_PER_CYCLE];
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (finish) begin
        quo_q  <= (dvs_q == '0) ? '0 : dvd_next;
        remo_q <= (dvs_q == '0) ? '0 : rem_c[BITS_PER_CYCLE];
      end
    end
  end

  assign o_busy      = busy_q;
  assign o_valid     = valid_q;
  assign o_quotient  = quo_q;
  assign o_remainder = remo_q;

endmodule

// File: tb/tb_lc4_divider_seq.sv
// Self-checking bench for lc4_divider_seq at BITS_PER_CYCLE 1 and 4.
module tb_lc4_divider_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, start4;
  logic [15:0] dividend, divisor;
  logic        busy1, valid1, busy4, valid4;
  logic [15:0] quo1, rem1, quo4, rem4;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  lc4_divider_seq #(.BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .i_start(start1), .i_dividend(dividend), .i_divisor(divisor),
    .o_busy(busy1), .o_valid(valid1), .o_quotient(quo1), .o_remainder(rem1)
  );

  lc4_divider_seq #(.BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .i_start(start4), .i_dividend(dividend), .i_divisor(divisor),
    .o_busy(busy4), .o_valid(valid4), .o_quotient(quo4), .o_remainder(rem4)
  );

  // Reference: plain integer division, divide-by-zero yields (0, 0).
  function automatic logic [15:0] ref_q(input logic [15:0] a, input logic [15:0] b);
    return (b == 16'd0) ? 16'd0 : a / b;
  endfunction
  function automatic logic [15:0] ref_r(input logic [15:0] a, input logic [15:0] b);
    return (b == 16'd0) ? 16'd0 : a % b;
  endfunction

  function automatic logic get_valid(input int w);
    return (w == 4) ? valid4 : valid1;
  endfunction
  function automatic logic get_busy(input int w);
    return (w == 4) ? busy4 : busy1;
  endfunction
  function automatic logic [15:0] get_q(input int w);
    return (w == 4) ? quo4 : quo1;
  endfunction
  function automatic logic [15:0] get_r(input int w);
    return (w == 4) ? rem4 : rem1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Called at the negedge after the start edge; edges counts that start edge as 1.
  task automatic wait_valid(input int w, output int edges, output int busy_cycles);
    edges = 1;
    busy_cycles = 0;
    while (edges <= 40) begin
      if (get_busy(w)) busy_cycles++;
      if (get_valid(w)) break;
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic run_div(input int w, input logic [15:0] a, input logic [15:0] b, input string tag);
    int edges, bc;
    logic [15:0] eq, er;
    eq = ref_q(a, b);
    er = ref_r(a, b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    if (w == 4) start4 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1   = 1'b0;
    start4   = 1'b0;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
    wait_valid(w, edges, bc);
    check({tag, ".latency"}, 32'(edges), (w == 4) ? 32'd5 : 32'd17);
    check({tag, ".busy_cycles"}, 32'(bc), (w == 4) ? 32'd4 : 32'd16);
    check({tag, ".quotient"}, 32'(get_q(w)), 32'(eq));
    check({tag, ".remainder"}, 32'(get_r(w)), 32'(er));
    @(negedge clk);
    check({tag, ".valid_pulse"}, 32'(get_valid(w)), 32'd0);
    check({tag, ".hold_q"}, 32'(get_q(w)), 32'(eq));
  endtask

  initial begin
    int edges, bc, nvalid, first_lat;
    logic [15:0] cq, cr, a, b;

    rst = 1'b1; start1 = 1'b0; start4 = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.busy", 32'(busy1), 32'd0);
    check("reset.valid", 32'(valid1), 32'd0);
    check("reset.quotient", 32'(quo1), 32'd0);
    check("reset.remainder", 32'(rem1), 32'd0);
    check("reset.busy4", 32'(busy4), 32'd0);
    rst = 1'b0;

    run_div(1, 16'd100, 16'd7, "div_100_7");
    run_div(1, 16'hFFFF, 16'd1, "div_ffff_1");
    run_div(1, 16'hFFFF, 16'hFFFF, "div_ffff_ffff");
    run_div(1, 16'd3, 16'hFFFF, "div_3_ffff");
    run_div(1, 16'd5, 16'd0, "div_5_0");

    // Start while busy is ignored.
    @(negedge clk);
    dividend = 16'd40; divisor = 16'd3; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    edges = 1; nvalid = 0; first_lat = 0; cq = '0; cr = '0;
    for (int c = 0; c < 40; c++) begin
      if (edges == 5) begin
        start1 = 1'b1; dividend = 16'd9; divisor = 16'd2;
      end else begin
        start1 = 1'b0;
      end
      if (valid1) begin
        nvalid++;
        if (first_lat == 0) begin
          first_lat = edges; cq = quo1; cr = rem1;
        end
      end
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    check("ignore_start.valid_count", 32'(nvalid), 32'd1);
    check("ignore_start.latency", 32'(first_lat), 32'd17);
    check("ignore_start.quotient", 32'(cq), 32'd13);
    check("ignore_start.remainder", 32'(cr), 32'd1);

    // Reset mid-divide aborts.
    dividend = 16'd40; divisor = 16'd3; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    repeat (7) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort.busy", 32'(busy1), 32'd0);
    check("abort.valid", 32'(valid1), 32'd0);
    check("abort.quotient", 32'(quo1), 32'd0);
    check("abort.remainder", 32'(rem1), 32'd0);
    nvalid = 0;
    for (int c = 0; c < 25; c++) begin
      if (valid1) nvalid++;
      @(posedge clk);
      @(negedge clk);
    end
    check("abort.no_valid", 32'(nvalid), 32'd0);
    run_div(1, 16'd9, 16'd2, "after_abort");

    // Back-to-back at 4 bits per cycle, second start in the DONE cycle.
    @(negedge clk);
    dividend = 16'd1000; divisor = 16'd10; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    wait_valid(4, edges, bc);
    check("b2b.first_latency", 32'(edges), 32'd5);
    check("b2b.first_quotient", 32'(quo4), 32'd100);
    check("b2b.first_remainder", 32'(rem4), 32'd0);
    dividend = 16'd1000; divisor = 16'd33; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    check("b2b.rebusy", 32'(busy4), 32'd1);
    check("b2b.hold_first", 32'(quo4), 32'd100);
    wait_valid(4, edges, bc);
    check("b2b.second_latency", 32'(edges), 32'd5);
    check("b2b.second_quotient", 32'(quo4), 32'd30);
    check("b2b.second_remainder", 32'(rem4), 32'd10);

    // Randomized operands on both configurations.
    for (int i = 0; i < 12; i++) begin
      a = 16'($urandom);
      b = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom >> $urandom_range(0, 15));
      run_div(1, a, b, $sformatf("rand1_%0d_%0d", a, b));
    end
    for (int i = 0; i < 10; i++) begin
      a = 16'($urandom);
      b = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom >> $urandom_range(0, 15));
      run_div(4, a, b, $sformatf("rand4_%0d_%0d", a, b));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
